// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: per-symbol enable sequencer and traceback address generator for the Viterbi datapath.
// Zero-tail symbol insertion is compiled in by defining VITERBI_CTRL_TAIL_EN.
module viterbi_ctrl #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned TAIL_LEN  = 2,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_rx_valid,
  output logic              o_ready,
  output logic              o_en_b,
  output logic              o_en_a,
  output logic              o_en_s,
  output logic              o_en_t,
  output logic              o_tail,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state
);

`ifdef VITERBI_CTRL_TAIL_EN
  localparam bit TAIL_ON = 1'b1;
`else
  localparam bit TAIL_ON = 1'b0;
`endif

  localparam int unsigned NUM_SYM = TAIL_ON ? (FRAME_LEN + TAIL_LEN) : FRAME_LEN;
  localparam logic [ADDR_W-1:0] LAST_DATA = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_SYM  = ADDR_W'(NUM_SYM - 1);
  localparam logic [ADDR_W-1:0] FIRST_TAIL = ADDR_W'(FRAME_LEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_BM   = 3'd2;
  localparam logic [2:0] S_ACS  = 3'd3;
  localparam logic [2:0] S_SAVE = 3'd4;
  localparam logic [2:0] S_TB   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] wr_n, rd_n;
  logic              tail_n;

  // Next-state / counter logic; outputs are decoded from the next state and registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = o_wr_addr;
    rd_n    = o_rd_addr;
    tail_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end
      end
      S_WAIT: if (i_rx_valid) state_n = S_BM;
      S_BM:   state_n = S_ACS;
      S_ACS:  state_n = S_SAVE;
      S_SAVE: begin
        if (cnt == LAST_SYM) begin
          state_n = S_TB;
          cnt_n   = LAST_SYM;
        end else begin
          cnt_n   = cnt + ADDR_W'(1);
          // Tail symbols are generated internally, so they never wait for a source symbol.
          state_n = (TAIL_ON && (cnt >= LAST_DATA)) ? S_BM : S_WAIT;
        end
      end
      S_TB: begin
        if (cnt == '0) state_n = S_DONE;
        else           cnt_n   = cnt - ADDR_W'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (i_abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end

    if (state_n == S_SAVE) wr_n = cnt_n;
    if (state_n == S_TB)   rd_n = cnt_n;
`ifdef VITERBI_CTRL_TAIL_EN
    tail_n = ((state_n == S_BM) || (state_n == S_ACS) || (state_n == S_SAVE)) &&
             (cnt_n >= FIRST_TAIL);
`else
    tail_n = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      o_ready   <= 1'b0;
      o_en_b    <= 1'b0;
      o_en_a    <= 1'b0;
      o_en_s    <= 1'b0;
      o_en_t    <= 1'b0;
      o_tail    <= 1'b0;
      o_wr_addr <= '0;
      o_rd_addr <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      o_ready   <= (state_n == S_WAIT);
      o_en_b    <= (state_n == S_BM);
      o_en_a    <= (state_n == S_ACS);
      o_en_s    <= (state_n == S_SAVE);
      o_en_t    <= (state_n == S_TB);
      o_tail    <= tail_n;
      o_wr_addr <= wr_n;
      o_rd_addr <= rd_n;
      o_busy    <= (state_n != S_IDLE);
      o_done    <= (state_n == S_DONE);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl: vector table, directed frame/abort sequences and a randomized run
// against a queue-based frame model. Works with or without VITERBI_CTRL_TAIL_EN.
module tb_viterbi_ctrl;

  localparam int FL = 4;
  localparam int TL = 2;
`ifdef VITERBI_CTRL_TAIL_EN
  localparam int NS = FL + TL;
`else
  localparam int NS = FL;
`endif

  logic       clk;
  logic       rst;
  logic       start, abort, valid;
  logic       ready, en_b, en_a, en_s, en_t, tail, busy, done;
  logic [9:0] wr_addr, rd_addr;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  viterbi_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_rx_valid(valid),
    .o_ready(ready), .o_en_b(en_b), .o_en_a(en_a), .o_en_s(en_s), .o_en_t(en_t),
    .o_tail(tail), .o_wr_addr(wr_addr), .o_rd_addr(rd_addr), .o_busy(busy),
    .o_done(done), .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ready, en_b, en_a, en_s, en_t, tail, busy, done;
    logic [9:0] wr;
    logic [9:0] rd;
  } out_t;

  typedef struct {
    logic       start, abort, valid;
    logic [2:0] st;
    logic       ready;
    logic [3:0] en;
    logic [9:0] wr;
    logic       busy;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.st = state; o.ready = ready; o.en_b = en_b; o.en_a = en_a; o.en_s = en_s;
    o.en_t = en_t; o.tail = tail; o.busy = busy; o.done = done;
    o.wr = wr_addr; o.rd = rd_addr;
    return o;
  endfunction

  function automatic vec_t mk(input logic s, input logic a, input logic v, input logic [2:0] st,
                              input logic r, input logic [3:0] en, input logic [9:0] wr,
                              input logic b);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.st = st; t.ready = r; t.en = en; t.wr = wr; t.busy = b;
    return t;
  endfunction

  // ---------------- frame model: scripts fixed-length phases into a queue ----------------
  out_t       mq[$];
  out_t       cur;
  int         mode;        // 0 idle, 1 waiting for a symbol, 2 running a script
  int         k;
  bit         after_wait;
  logic [9:0] lw, lr;

  function automatic out_t rec(input logic [2:0] st);
    out_t r = '0;
    r.st = st;
    r.busy = (st != 3'd0);
    r.ready = (st == 3'd1);
    return r;
  endfunction

  task automatic set_cur(input out_t r);
    out_t t = r;
    if (t.en_s) lw = t.wr; else t.wr = lw;
    if (t.en_t) lr = t.rd; else t.rd = lr;
    cur = t;
  endtask

  task automatic push_symbol(input int idx);
    out_t r;
    r = rec(3'd2); r.en_b = 1'b1; r.tail = (idx >= FL); mq.push_back(r);
    r = rec(3'd3); r.en_a = 1'b1; r.tail = (idx >= FL); mq.push_back(r);
    r = rec(3'd4); r.en_s = 1'b1; r.tail = (idx >= FL); r.wr = 10'(idx); mq.push_back(r);
  endtask

  task automatic model_reset();
    mq.delete();
    mode = 0; k = 0; after_wait = 1'b0;
    lw = '0; lr = '0;
    cur = rec(3'd0);
  endtask

  task automatic model_step(input logic s, input logic a, input logic v);
    out_t r;
    if (a && mode != 0) begin
      mq.delete(); mode = 0; set_cur(rec(3'd0));
    end else if (mq.size() > 0) begin
      set_cur(mq.pop_front());
    end else if (mode == 2) begin
      if (after_wait) begin k++; mode = 1; set_cur(rec(3'd1)); end
      else begin mode = 0; set_cur(rec(3'd0)); end
    end else if (mode == 0) begin
      if (s && !a) begin mode = 1; k = 0; set_cur(rec(3'd1)); end
      else set_cur(rec(3'd0));
    end else begin
      if (v) begin
        push_symbol(k);
        if (k == FL - 1) begin
          for (int j = FL; j < NS; j++) push_symbol(j);
          for (int t = 0; t < NS; t++) begin
            r = rec(3'd5); r.en_t = 1'b1; r.rd = 10'(NS - 1 - t); mq.push_back(r);
          end
          r = rec(3'd6); r.done = 1'b1; mq.push_back(r);
          after_wait = 1'b0;
        end else begin
          after_wait = 1'b1;
        end
        mode = 2;
        set_cur(mq.pop_front());
      end else begin
        set_cur(rec(3'd1));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", int'(sample()), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  vec_t tbl[18];
  int   wq[$], wc[$], wt[$], rq[$], rc[$];
  int   dcount, dcyc, busy_after, bad_ready;
  bit   found;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
    model_reset();

    // Test 1: reset then idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d", c), int'(sample()), 0);
    end

    // Vector table: stall, ignored start/valid, start+abort in IDLE, abort in WAIT
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 10'd0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 4'b0000, 10'd0, 1'b1);
    for (int i = 2; i < 7; i++) tbl[i] = mk(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'b0000, 10'd0, 1'b1);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 4'b0000, 10'd0, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'b1000, 10'd0, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 4'b0100, 10'd0, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 4'b0010, 10'd0, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'b0000, 10'd0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 4'b1000, 10'd0, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 4'b0100, 10'd0, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 4'b0010, 10'd1, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'b0000, 10'd1, 1'b1);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0000, 10'd1, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000, 10'd1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      start = tbl[i].start; abort = tbl[i].abort; valid = tbl[i].valid;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            int'({state, ready, en_b, en_a, en_s, en_t, wr_addr, busy}),
            int'({tbl[i].st, tbl[i].ready, tbl[i].en, tbl[i].wr, tbl[i].busy}));
    end

    // Test 2 / 6: full frame with valid held high
    do_reset();
    dcount = 0; dcyc = -10; busy_after = -1; bad_ready = 0;
    start = 1'b1; valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (en_s) begin wq.push_back(int'(wr_addr)); wc.push_back(c); wt.push_back(int'(tail)); end
      if (en_t) begin rq.push_back(int'(rd_addr)); rc.push_back(c); end
      if (tail && ready) bad_ready++;
      if (done) begin dcount++; dcyc = c; end
      if (c == dcyc + 1) busy_after = int'(busy);
    end
    valid = 1'b0;
    check("wr_count", wq.size(), NS);
    check("rd_count", rq.size(), NS);
    if (wq.size() == NS && rq.size() == NS) begin
      for (int i = 0; i < NS; i++) begin
        check($sformatf("wr_addr%0d", i), wq[i], i);
        check($sformatf("wr_tail%0d", i), wt[i], (i >= FL) ? 1 : 0);
        if (i > 0) check($sformatf("wr_gap%0d", i), wc[i] - wc[i-1], (i >= FL) ? 3 : 4);
        check($sformatf("rd_addr%0d", i), rq[i], NS - 1 - i);
        check($sformatf("rd_cyc%0d", i), rc[i], wc[NS-1] + 1 + i);
      end
      check("done_cyc", dcyc, rc[NS-1] + 1);
    end
    check("done_count", dcount, 1);
    check("busy_after_done", busy_after, 0);
    check("tail_ready", bad_ready, 0);

    // Test 4: abort during traceback at read address 2
    do_reset();
    found = 1'b0;
    start = 1'b1; valid = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (en_t && rd_addr == 10'd2) found = 1'b1;
    end
    check("tb_reach", int'(found), 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_state", int'(state), 0);
    check("abort_en_t", int'(en_t), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    abort = 1'b0; valid = 1'b0;
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_idle", int'(state), 0);
    @(negedge clk);
    start = 1'b1; valid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (en_s) begin
        found = 1'b1;
        check("restart_wr", int'(wr_addr), 0);
      end
    end
    check("restart_save", int'(found), 1);

    // Randomized run against the frame model, including rare mid-frame resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 49) == 0);
      valid = ($urandom_range(0, 2) != 0);
      if (!rst) model_reset();
      else      model_step(start, abort, valid);
      @(posedge clk); #1;
      check($sformatf("rand%0d", c), int'(sample()), int'(cur));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
